rib_dram_slave: RTL and testbench

Data-memory responder for the core's RIB memory bus. It accepts the read requests that the ID/EX stage raises during load decode, and the write requests raised by EX for stores. Reads return word data after a programmable latency with a single-cycle valid strobe. Writes commit with per-byte enables and a one-cycle acknowledge. It sits between the core pipeline and the on-chip data RAM, and drives the busy indication that the hold/stall controller uses to freeze the front of the pipeline.

---
 rtl/rib_dram_slave.sv | 145 ++++++++++++++
 tb/tb_rib_dram_slave.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rib_dram_slave.sv
// RIB data-memory responder: latency-programmable word reads,
// byte-enabled single-cycle writes, busy while a read is in flight.
module rib_dram_slave #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                DEPTH_WORDS = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h1000_0000,
  parameter int                RD_LATENCY  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_req_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic              rd_err_o,
  input  logic              wr_req_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [3:0]        wr_be_i,
  output logic              wr_ack_o,
  output logic              wr_err_o,
  output logic              busy_o
);

  localparam int IW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state, state_nx;
  logic [1:0] cnt, cnt_nx;
  logic [IW-1:0] lat_idx;
  logic lat_err;

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // word offsets; a wrap below BASE_ADDR lands in the high bits
  logic [ADDR_W-3:0] rd_woff, wr_woff;
  logic [IW-1:0] rd_idx, wr_idx, sel_idx;
  logic rd_err_now, wr_err_now, sel_err;
  logic wr_ok;
  logic [DATA_W-1:0] merged;

  assign rd_woff = rd_addr_i[ADDR_W-1:2]
                 - BASE_ADDR[ADDR_W-1:2];
  assign wr_woff = wr_addr_i[ADDR_W-1:2]
                 - BASE_ADDR[ADDR_W-1:2];

  assign rd_idx = rd_woff[IW-1:0];
  assign wr_idx = wr_woff[IW-1:0];

  assign rd_err_now = (rd_addr_i[1:0] != 2'b00)
                    || (|rd_woff[ADDR_W-3:IW]);
  assign wr_err_now = (wr_addr_i[1:0] != 2'b00)
                    || (|wr_woff[ADDR_W-3:IW]);

  assign wr_ok = wr_req_i && !wr_err_now;

  // with latency 1 the RESP-entry edge is the request edge
  assign sel_idx = (state == IDLE) ? rd_idx : lat_idx;
  assign sel_err = (state == IDLE) ? rd_err_now : lat_err;

  always_comb begin
    merged = mem[sel_idx];
    if (wr_ok && (wr_idx == sel_idx)) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be_i[b]) merged[8*b +: 8] = wr_data_i[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (rd_req_i) begin
          if (RD_LATENCY == 1) begin
            state_nx = RESP;
          end else begin
            state_nx = WAIT;
            cnt_nx   = 2'(RD_LATENCY - 2);
          end
        end
      end
      WAIT: begin
        if (cnt == 2'd0) state_nx = RESP;
        else             cnt_nx   = cnt - 2'd1;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 2'd0;
      lat_idx <= '0;
      lat_err <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (state == IDLE && rd_req_i) begin
        lat_idx <= rd_idx;
        lat_err <= rd_err_now;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_o  <= '0;
      rd_valid_o <= 1'b0;
      rd_err_o   <= 1'b0;
      wr_ack_o   <= 1'b0;
      wr_err_o   <= 1'b0;
    end else begin
      rd_valid_o <= (state_nx == RESP);
      if (state_nx == RESP) begin
        rd_err_o  <= sel_err;
        rd_data_o <= sel_err ? '0 : merged;
      end else begin
        rd_err_o  <= 1'b0;
      end
      wr_ack_o <= wr_req_i;
      wr_err_o <= wr_req_i && wr_err_now;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be_i[b]) mem[wr_idx][8*b +: 8] <= wr_data_i[8*b +: 8];
      end
    end
  end

  assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_rib_dram_slave.sv
// Bench for rib_dram_slave: three instances (read latency 1, 3, 4)
// checked by directed tables, hand sequences and a random model run.
module tb_rib_dram_slave;

  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h1000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        rd_req   [3];
  logic [31:0] rd_addr  [3];
  logic [31:0] rd_data  [3];
  logic        rd_valid [3];
  logic        rd_err   [3];
  logic        wr_req   [3];
  logic [31:0] wr_addr  [3];
  logic [31:0] wr_data  [3];
  logic [3:0]  wr_be    [3];
  logic        wr_ack   [3];
  logic        wr_err   [3];
  logic        busy     [3];

  int errors = 0;
  int checks = 0;
  logic [31:0] m [3][DEPTH];

  rib_dram_slave #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE),
                   .RD_LATENCY(1)) u0 (
    .clk(clk), .rst_n(rst_n),
    .rd_req_i(rd_req[0]), .rd_addr_i(rd_addr[0]),
    .rd_data_o(rd_data[0]), .rd_valid_o(rd_valid[0]),
    .rd_err_o(rd_err[0]), .wr_req_i(wr_req[0]),
    .wr_addr_i(wr_addr[0]), .wr_data_i(wr_data[0]),
    .wr_be_i(wr_be[0]), .wr_ack_o(wr_ack[0]),
    .wr_err_o(wr_err[0]), .busy_o(busy[0]));

  rib_dram_slave #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE),
                   .RD_LATENCY(3)) u1 (
    .clk(clk), .rst_n(rst_n),
    .rd_req_i(rd_req[1]), .rd_addr_i(rd_addr[1]),
    .rd_data_o(rd_data[1]), .rd_valid_o(rd_valid[1]),
    .rd_err_o(rd_err[1]), .wr_req_i(wr_req[1]),
    .wr_addr_i(wr_addr[1]), .wr_data_i(wr_data[1]),
    .wr_be_i(wr_be[1]), .wr_ack_o(wr_ack[1]),
    .wr_err_o(wr_err[1]), .busy_o(busy[1]));

  rib_dram_slave #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE),
                   .RD_LATENCY(4)) u2 (
    .clk(clk), .rst_n(rst_n),
    .rd_req_i(rd_req[2]), .rd_addr_i(rd_addr[2]),
    .rd_data_o(rd_data[2]), .rd_valid_o(rd_valid[2]),
    .rd_err_o(rd_err[2]), .wr_req_i(wr_req[2]),
    .wr_addr_i(wr_addr[2]), .wr_data_i(wr_data[2]),
    .wr_be_i(wr_be[2]), .wr_ack_o(wr_ack[2]),
    .wr_err_o(wr_err[2]), .busy_o(busy[2]));

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    bit          e;
    logic [31:0] rd;
  } vec_t;

  vec_t tv [12];

  function automatic int lat(int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
  endfunction

  function automatic bit m_err(logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (a % 4 != 0) || (off / 4 >= DEPTH);
  endfunction

  function automatic int m_idx(logic [31:0] a);
    logic [31:0] off;
    off = (a - BASE) / 4;
    return int'(off);
  endfunction

  task automatic m_write(int k, logic [31:0] a,
                         logic [31:0] d, logic [3:0] be);
    if (!m_err(a)) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) m[k][m_idx(a)][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chkb(string nm, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic do_write(int k, logic [31:0] a, logic [31:0] d,
                          logic [3:0] be, bit e);
    wr_req[k]  = 1'b1;
    wr_addr[k] = a;
    wr_data[k] = d;
    wr_be[k]   = be;
    tick();
    wr_req[k] = 1'b0;
    chkb("wr_ack", wr_ack[k], 1'b1);
    chkb("wr_err", wr_err[k], e);
    m_write(k, a, d, be);
    tick();
    chkb("wr_ack_drop", wr_ack[k], 1'b0);
  endtask

  task automatic do_read(int k, logic [31:0] a,
                         logic [31:0] exp_d, bit exp_e);
    int cyc;
    rd_req[k]  = 1'b1;
    rd_addr[k] = a;
    tick();
    rd_req[k] = 1'b0;
    cyc = 1;
    while (!rd_valid[k] && cyc < 8) begin
      chkb("busy_wait", busy[k], 1'b1);
      tick();
      cyc++;
    end
    chk("rd_latency", 32'(cyc), 32'(lat(k)));
    chkb("rd_valid", rd_valid[k], 1'b1);
    chkb("busy_resp", busy[k], 1'b1);
    chk("rd_data", rd_data[k], exp_d);
    chkb("rd_err", rd_err[k], exp_e);
    tick();
    chkb("rd_valid_drop", rd_valid[k], 1'b0);
    chkb("busy_idle", busy[k], 1'b0);
  endtask

  task automatic chk_zero(int k, string nm);
    chk({nm, "_rd_data"}, rd_data[k], 32'h0);
    chkb({nm, "_rd_valid"}, rd_valid[k], 1'b0);
    chkb({nm, "_rd_err"}, rd_err[k], 1'b0);
    chkb({nm, "_wr_ack"}, wr_ack[k], 1'b0);
    chkb({nm, "_wr_err"}, wr_err[k], 1'b0);
    chkb({nm, "_busy"}, busy[k], 1'b0);
  endtask

  initial begin
    logic [31:0] a, d, exp_d;
    logic [3:0]  be;
    bit          seen;

    for (int k = 0; k < 3; k++) begin
      rd_req[k] = 1'b0; rd_addr[k] = '0;
      wr_req[k] = 1'b0; wr_addr[k] = '0;
      wr_data[k] = '0;  wr_be[k] = '0;
    end

    repeat (3) tick();
    for (int k = 0; k < 3; k++) chk_zero(k, "reset");
    rst_n = 1'b1;
    tick();

    // defined contents so every later read has a known answer
    for (int i = 0; i < DEPTH; i++) begin
      for (int k = 0; k < 3; k++) begin
        wr_req[k]  = 1'b1;
        wr_addr[k] = BASE + 32'(4 * i);
        wr_data[k] = 32'h0;
        wr_be[k]   = 4'hF;
        m[k][i]    = 32'h0;
      end
      tick();
    end
    for (int k = 0; k < 3; k++) wr_req[k] = 1'b0;
    tick();

    tv[0]  = '{1, 32'h1000_0010, 32'hDEAD_BEEF, 4'hF, 0, 32'h0};
    tv[1]  = '{0, 32'h1000_0010, 32'h0, 4'h0, 0, 32'hDEAD_BEEF};
    tv[2]  = '{1, 32'h1000_0010, 32'h00AA_0000, 4'h4, 0, 32'h0};
    tv[3]  = '{0, 32'h1000_0010, 32'h0, 4'h0, 0, 32'hDEAA_BEEF};
    tv[4]  = '{0, 32'h1000_0012, 32'h0, 4'h0, 1, 32'h0};
    tv[5]  = '{0, 32'h0FFF_FFFC, 32'h0, 4'h0, 1, 32'h0};
    tv[6]  = '{0, 32'h1000_0400, 32'h0, 4'h0, 1, 32'h0};
    tv[7]  = '{1, 32'h1000_0400, 32'hFFFF_FFFF, 4'hF, 1, 32'h0};
    tv[8]  = '{1, 32'h0FFF_FFFC, 32'hFFFF_FFFF, 4'hF, 1, 32'h0};
    tv[9]  = '{0, 32'h1000_0000, 32'h0, 4'h0, 0, 32'h0};
    tv[10] = '{1, 32'h1000_0010, 32'h1111_1111, 4'h0, 0, 32'h0};
    tv[11] = '{0, 32'h1000_0010, 32'h0, 4'h0, 0, 32'hDEAA_BEEF};

    for (int i = 0; i < 12; i++) begin
      if (tv[i].wr) do_write(0, tv[i].addr, tv[i].data,
                             tv[i].be, tv[i].e);
      else          do_read(0, tv[i].addr, tv[i].rd, tv[i].e);
    end
    do_read(0, BASE + 32'(4 * (DEPTH - 1)), 32'h0, 0);
    do_read(0, 32'h0FFF_FFFC, 32'h0, 1);

    // held request on latency 3: responses every 4 cycles
    for (int i = 0; i < 4; i++)
      do_write(1, 32'h1000_0040 + 32'(4 * i),
               32'hA5A5_0000 + 32'(i), 4'hF, 0);
    rd_req[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rd_addr[1] = 32'h1000_0040 + 32'(4 * i);
      tick();
      for (int c = 1; c <= 4; c++) begin
        if (i == 3 && c == 4) rd_req[1] = 1'b0;
        chkb("stall_busy", busy[1], c <= 3);
        chkb("stall_valid", rd_valid[1], c == 3);
        if (c == 3)
          chk("stall_data", rd_data[1], 32'hA5A5_0000 + 32'(i));
        if (c < 4) tick();
      end
    end
    rd_req[1] = 1'b0;
    tick();

    // same-cycle read and write, latency 1
    rd_req[0]  = 1'b1; rd_addr[0] = 32'h1000_0020;
    wr_req[0]  = 1'b1; wr_addr[0] = 32'h1000_0020;
    wr_data[0] = 32'h1234_5678; wr_be[0] = 4'hF;
    tick();
    rd_req[0] = 1'b0; wr_req[0] = 1'b0;
    m_write(0, 32'h1000_0020, 32'h1234_5678, 4'hF);
    chkb("coll1_valid", rd_valid[0], 1'b1);
    chk("coll1_data", rd_data[0], 32'h1234_5678);
    chkb("coll1_ack", wr_ack[0], 1'b1);
    tick();

    // write landing on the RESP-entry edge, latency 3
    rd_req[1] = 1'b1; rd_addr[1] = 32'h1000_0030;
    tick();
    rd_req[1] = 1'b0;
    tick();
    wr_req[1]  = 1'b1; wr_addr[1] = 32'h1000_0030;
    wr_data[1] = 32'hAABB_CCDD; wr_be[1] = 4'b0011;
    tick();
    wr_req[1] = 1'b0;
    m_write(1, 32'h1000_0030, 32'hAABB_CCDD, 4'b0011);
    chkb("coll3_valid", rd_valid[1], 1'b1);
    chk("coll3_data", rd_data[1], 32'h0000_CCDD);
    tick();
    do_read(1, 32'h1000_0030, 32'h0000_CCDD, 0);

    // reset two cycles into a latency-4 read
    do_write(2, 32'h1000_0050, 32'hCAFE_F00D, 4'hF, 0);
    rd_req[2] = 1'b1; rd_addr[2] = 32'h1000_0050;
    tick();
    rd_req[2] = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk_zero(2, "midrst");
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (rd_valid[2] || busy[2]) seen = 1'b1;
      tick();
    end
    chkb("midrst_no_resp", seen, 1'b0);
    do_read(2, 32'h1000_0050, 32'hCAFE_F00D, 0);

    for (int n = 0; n < 150; n++) begin
      int k;
      int r;
      k = $urandom_range(0, 2);
      r = $urandom_range(0, 9);
      if (r == 0)
        a = BASE - 32'(4 * $urandom_range(1, 3));
      else if (r == 1)
        a = BASE + 32'(4 * $urandom_range(0, 299))
          + 32'($urandom_range(1, 3));
      else
        a = BASE + 32'(4 * $urandom_range(0, 299));
      if ($urandom_range(0, 1) == 1) begin
        d  = $urandom;
        be = 4'($urandom_range(0, 15));
        do_write(k, a, d, be, m_err(a));
      end else begin
        exp_d = m_err(a) ? 32'h0 : m[k][m_idx(a)];
        do_read(k, a, exp_d, m_err(a));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
